// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle control unit: FSM state
// encodings, instruction classes, datapath select codes and MIPS fields.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    IC_NONE,
    IC_ADDU,
    IC_SUBU,
    IC_ORI,
    IC_LUI,
    IC_LW,
    IC_SW,
    IC_BEQ,
    IC_J
  } instr_class_e;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_OR  = 5'd2;
  localparam logic [4:0] ALU_LUI = 5'd3;

  localparam logic [2:0] EXT_ZERO = 3'd0;
  localparam logic [2:0] EXT_SIGN = 3'd1;

  localparam logic [1:0] NPC_SEQ    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;

  localparam logic [1:0] CMP_EQ = 2'b00;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;

  // R-type instructions write their result to rd instead of rt.
  function automatic logic is_rtype(input instr_class_e cls);
    return (cls == IC_ADDU) || (cls == IC_SUBU);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Instruction decoder: classifies the instruction register contents into one
// of the supported instruction classes and flags unsupported encodings.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0]  curr_instr,
  output instr_class_e instr_class,
  output logic         instr_valid
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = curr_instr[31:26];
  assign funct         = curr_instr[5:0];
  assign unused_fields = ^curr_instr[25:6];

  // Map opcode (and funct for R-type) onto an instruction class.
  always_comb begin
    instr_class = IC_NONE;
    unique case (opcode)
      OP_RTYPE: begin
        if (funct == FUNCT_ADDU) begin
          instr_class = IC_ADDU;
        end else if (funct == FUNCT_SUBU) begin
          instr_class = IC_SUBU;
        end
      end
      OP_ORI:  instr_class = IC_ORI;
      OP_LUI:  instr_class = IC_LUI;
      OP_LW:   instr_class = IC_LW;
      OP_SW:   instr_class = IC_SW;
      OP_BEQ:  instr_class = IC_BEQ;
      OP_J:    instr_class = IC_J;
      default: instr_class = IC_NONE;
    endcase
  end

  assign instr_valid = (instr_class != IC_NONE);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// memory wait timeout, retired-instruction counter and absorbing HALT state.
module mc_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] curr_instr,
  input  logic [1:0]  alu_comp_result,
  input  logic        mem_ready,
  output logic        cw_pc_enable,
  output logic        cw_im_enable,
  output logic        cw_ir_load,
  output logic        cw_rf_write_enable,
  output logic        cw_dm_write_enable,
  output logic        cw_dm_read_enable,
  output logic [1:0]  cw_npc_jump_mode,
  output logic [4:0]  cw_alu_op,
  output logic [2:0]  cw_ext_mode,
  output logic        cm_rf_write_addr,
  output logic        cm_rf_write_data,
  output logic        cm_alu_num2,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] instr_count
);

  // The counter only ever holds 0..MEM_TIMEOUT-1; reaching the last value
  // with another wait means the timeout fires instead of incrementing.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]       instr_count_q, instr_count_d;
  instr_class_e      instr_class;
  logic              instr_valid;

  mc_decode u_decode (
    .curr_instr  (curr_instr),
    .instr_class (instr_class),
    .instr_valid (instr_valid)
  );

  // Next-state, wait counter and strobe generation; reset forces strobes low.
  always_comb begin
    state_d            = state_q;
    wait_cnt_d         = wait_cnt_q;
    cw_pc_enable       = 1'b0;
    cw_im_enable       = 1'b0;
    cw_ir_load         = 1'b0;
    cw_rf_write_enable = 1'b0;
    cw_dm_write_enable = 1'b0;
    cw_dm_read_enable  = 1'b0;
    cw_npc_jump_mode   = NPC_SEQ;

    unique case (state_q)
      ST_FETCH: begin
        cw_im_enable = 1'b1;
        cw_ir_load   = 1'b1;
        state_d      = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = instr_valid ? ST_EXEC : ST_HALT;
      end
      ST_EXEC: begin
        unique case (instr_class)
          IC_ADDU, IC_SUBU, IC_ORI, IC_LUI: state_d = ST_WB;
          IC_LW, IC_SW: begin
            wait_cnt_d = '0;
            state_d    = ST_MEM;
          end
          IC_BEQ: begin
            cw_pc_enable     = 1'b1;
            cw_npc_jump_mode = (alu_comp_result == CMP_EQ) ? NPC_BRANCH : NPC_SEQ;
            state_d          = ST_FETCH;
          end
          IC_J: begin
            cw_pc_enable     = 1'b1;
            cw_npc_jump_mode = NPC_JUMP;
            state_d          = ST_FETCH;
          end
          default: state_d = ST_HALT;
        endcase
      end
      ST_MEM: begin
        if ((instr_class == IC_LW) || (instr_class == IC_SW)) begin
          cw_dm_read_enable  = (instr_class == IC_LW);
          cw_dm_write_enable = (instr_class == IC_SW);
          if (mem_ready) begin
            if (instr_class == IC_LW) begin
              state_d = ST_WB;
            end else begin
              cw_pc_enable = 1'b1;
              state_d      = ST_FETCH;
            end
          end else if (wait_cnt_q == LAST_WAIT) begin
            state_d = ST_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_WB: begin
        cw_rf_write_enable = 1'b1;
        cw_pc_enable       = 1'b1;
        state_d            = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    if (!rst_n) begin
      cw_pc_enable       = 1'b0;
      cw_im_enable       = 1'b0;
      cw_ir_load         = 1'b0;
      cw_rf_write_enable = 1'b0;
      cw_dm_write_enable = 1'b0;
      cw_dm_read_enable  = 1'b0;
      cw_npc_jump_mode   = NPC_SEQ;
    end
  end

  // Datapath select lines follow the decoded instruction while it is live.
  always_comb begin
    cw_alu_op        = ALU_ADD;
    cw_ext_mode      = EXT_ZERO;
    cm_alu_num2      = 1'b0;
    cm_rf_write_addr = 1'b0;
    cm_rf_write_data = 1'b0;
    if (rst_n && (state_q != ST_HALT)) begin
      cm_rf_write_addr = is_rtype(instr_class);
      unique case (instr_class)
        IC_ADDU: cw_alu_op = ALU_ADD;
        IC_SUBU: cw_alu_op = ALU_SUB;
        IC_ORI: begin
          cw_alu_op   = ALU_OR;
          cw_ext_mode = EXT_ZERO;
          cm_alu_num2 = 1'b1;
        end
        IC_LUI: begin
          cw_alu_op   = ALU_LUI;
          cw_ext_mode = EXT_ZERO;
          cm_alu_num2 = 1'b1;
        end
        IC_LW: begin
          cw_alu_op        = ALU_ADD;
          cw_ext_mode      = EXT_SIGN;
          cm_alu_num2      = 1'b1;
          cm_rf_write_data = 1'b1;
        end
        IC_SW: begin
          cw_alu_op   = ALU_ADD;
          cw_ext_mode = EXT_SIGN;
          cm_alu_num2 = 1'b1;
        end
        IC_BEQ:  cw_alu_op = ALU_SUB;
        default: cw_alu_op = ALU_ADD;
      endcase
    end
  end

  // Every PC update retires one instruction; the counter wraps naturally.
  always_comb begin
    instr_count_d = instr_count_q + {31'd0, cw_pc_enable};
  end

  // State, wait counter and retired count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      wait_cnt_q    <= '0;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == ST_HALT);
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios followed by random
// instruction streams checked against a per-instruction phase model.
module tb_mc_control;

  localparam int TIMEOUT = 15;

  localparam int C_ADDU = 0;
  localparam int C_SUBU = 1;
  localparam int C_ORI  = 2;
  localparam int C_LUI  = 3;
  localparam int C_LW   = 4;
  localparam int C_SW   = 5;
  localparam int C_BEQ  = 6;
  localparam int C_J    = 7;
  localparam int C_BAD  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] curr_instr;
  logic [1:0]  alu_comp_result;
  logic        mem_ready;
  logic        cw_pc_enable, cw_im_enable, cw_ir_load;
  logic        cw_rf_write_enable, cw_dm_write_enable, cw_dm_read_enable;
  logic [1:0]  cw_npc_jump_mode;
  logic [4:0]  cw_alu_op;
  logic [2:0]  cw_ext_mode;
  logic        cm_rf_write_addr, cm_rf_write_data, cm_alu_num2;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] instr_count;
  logic [5:0]  strobes;

  int          pass_count = 0;
  int          check_count = 0;
  int          fail_count = 0;
  logic [31:0] model_count = 32'd0;
  logic        model_halted = 1'b0;

  mc_control #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .curr_instr         (curr_instr),
    .alu_comp_result    (alu_comp_result),
    .mem_ready          (mem_ready),
    .cw_pc_enable       (cw_pc_enable),
    .cw_im_enable       (cw_im_enable),
    .cw_ir_load         (cw_ir_load),
    .cw_rf_write_enable (cw_rf_write_enable),
    .cw_dm_write_enable (cw_dm_write_enable),
    .cw_dm_read_enable  (cw_dm_read_enable),
    .cw_npc_jump_mode   (cw_npc_jump_mode),
    .cw_alu_op          (cw_alu_op),
    .cw_ext_mode        (cw_ext_mode),
    .cm_rf_write_addr   (cm_rf_write_addr),
    .cm_rf_write_data   (cm_rf_write_data),
    .cm_alu_num2        (cm_alu_num2),
    .state              (state),
    .halted             (halted),
    .instr_count        (instr_count)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  assign strobes = {cw_pc_enable, cw_im_enable, cw_ir_load,
                    cw_rf_write_enable, cw_dm_write_enable, cw_dm_read_enable};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before checks.
  task automatic applyStimulus(input logic rst, input logic [31:0] instr,
                               input logic [1:0] cmp, input logic ready);
    @(negedge clk);
    rst_n           = rst;
    curr_instr      = instr;
    alu_comp_result = cmp;
    mem_ready       = ready;
    #1;
  endtask

  function automatic logic [31:0] makeInstr(input int cls);
    logic [25:0] f;
    logic [31:0] w;
    f = 26'($urandom);
    case (cls)
      C_ADDU: w = {6'h00, f[25:11], 5'd0, 6'h21};
      C_SUBU: w = {6'h00, f[25:11], 5'd0, 6'h23};
      C_ORI:  w = {6'h0d, f};
      C_LUI:  w = {6'h0f, f};
      C_LW:   w = {6'h23, f};
      C_SW:   w = {6'h2b, f};
      C_BEQ:  w = {6'h04, f};
      C_J:    w = {6'h02, f};
      default: begin
        case ($urandom_range(0, 2))
          0:       w = {6'h3f, f};
          1:       w = {6'h00, f[25:6], 6'h20};
          default: w = {6'h08, f};
        endcase
      end
    endcase
    return w;
  endfunction

  // Expected outputs for one cycle in a given phase (0 fetch, 1 decode,
  // 2 execute, 3 memory, 4 writeback, 7 halt) of an instruction class.
  task automatic checkCycle(input int phase, input int cls,
                            input logic [1:0] cmp, input logic ready);
    logic [5:0] exp_str;
    logic [1:0] exp_jm;
    logic [4:0] exp_alu;
    exp_str = 6'b000000;
    exp_jm  = 2'd0;
    case (phase)
      0: exp_str = 6'b011000;
      2: begin
        if (cls == C_BEQ) begin
          exp_str = 6'b100000;
          exp_jm  = (cmp == 2'b00) ? 2'd1 : 2'd0;
        end else if (cls == C_J) begin
          exp_str = 6'b100000;
          exp_jm  = 2'd2;
        end
      end
      3: begin
        if (cls == C_LW) exp_str = 6'b000001;
        else             exp_str = ready ? 6'b100010 : 6'b000010;
      end
      4: exp_str = 6'b100100;
      default: exp_str = 6'b000000;
    endcase
    checkOutput("state", 32'(state), 32'(phase));
    checkOutput("strobes", 32'(strobes), 32'(exp_str));
    checkOutput("jump_mode", 32'(cw_npc_jump_mode), 32'(exp_jm));
    checkOutput("halted", 32'(halted), 32'(phase == 7));
    checkOutput("instr_count", instr_count, model_count);
    if (phase == 2 && (cls <= C_SW || cls == C_BEQ)) begin
      case (cls)
        C_SUBU, C_BEQ: exp_alu = 5'd1;
        C_ORI:         exp_alu = 5'd2;
        C_LUI:         exp_alu = 5'd3;
        default:       exp_alu = 5'd0;
      endcase
      checkOutput("alu_op", 32'(cw_alu_op), 32'(exp_alu));
      checkOutput("alu_num2", 32'(cm_alu_num2), 32'(cls >= C_ORI && cls <= C_SW));
      if (cls >= C_ORI && cls <= C_SW)
        checkOutput("ext_mode", 32'(cw_ext_mode), 32'(cls >= C_LW));
    end
    if (phase == 4) begin
      checkOutput("rf_write_addr", 32'(cm_rf_write_addr), 32'(cls <= C_SUBU));
      checkOutput("rf_write_data", 32'(cm_rf_write_data), 32'(cls == C_LW));
    end
    if (exp_str[5]) model_count = model_count + 32'd1;
  endtask

  // Run one whole instruction: build its expected phase list, then step it.
  task automatic runInstr(input logic [31:0] instr, input int cls,
                          input logic [1:0] cmp, input int waits);
    int         phases[$];
    int         mem_i;
    logic       ready;
    logic [1:0] cmp_drv;
    phases = {0, 1};
    if (cls == C_BAD) begin
      phases.push_back(7);
    end else begin
      phases.push_back(2);
      if (cls <= C_LUI) phases.push_back(4);
      if (cls == C_LW || cls == C_SW) begin
        if (waits >= TIMEOUT) begin
          repeat (TIMEOUT) phases.push_back(3);
          phases.push_back(7);
        end else begin
          repeat (waits + 1) phases.push_back(3);
          if (cls == C_LW) phases.push_back(4);
        end
      end
    end
    mem_i = 0;
    foreach (phases[k]) begin
      ready   = (phases[k] == 3) ? (mem_i == waits) : 1'($urandom);
      cmp_drv = (phases[k] == 2) ? cmp : 2'($urandom);
      applyStimulus(1'b1, instr, cmp_drv, ready);
      checkCycle(phases[k], cls, cmp_drv, ready);
      if (phases[k] == 3) mem_i++;
    end
    model_halted = (phases[phases.size() - 1] == 7);
  endtask

  task automatic holdHalted(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(1'b1, 32'($urandom), 2'($urandom), 1'($urandom));
      checkCycle(7, C_BAD, 2'd0, 1'b0);
    end
  endtask

  task automatic applyReset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(1'b0, 32'($urandom), 2'($urandom), 1'($urandom));
      checkOutput("reset_strobes", 32'(strobes), 32'd0);
      checkOutput("reset_jump_mode", 32'(cw_npc_jump_mode), 32'd0);
    end
    model_count  = 32'd0;
    model_halted = 1'b0;
  endtask

  initial begin
    logic [31:0] instr;
    int          cls;
    int          r;
    int          waits;

    rst_n           = 1'b0;
    curr_instr      = 32'd0;
    alu_comp_result = 2'd0;
    mem_ready       = 1'b0;

    applyReset(2);

    // addu: rd select, one writeback, count 1 after the fourth cycle.
    runInstr(32'h00851021, C_ADDU, 2'd0, 0);

    // lw with three wait cycles before ready.
    runInstr(makeInstr(C_LW), C_LW, 2'd0, 3);

    // beq taken, then not taken.
    runInstr(makeInstr(C_BEQ), C_BEQ, 2'b00, 0);
    runInstr(makeInstr(C_BEQ), C_BEQ, 2'b01, 0);

    // lw whose ready arrives in the would-be timeout cycle.
    runInstr(makeInstr(C_LW), C_LW, 2'd0, TIMEOUT - 1);

    // sw that never sees ready: timeout into HALT, count frozen.
    runInstr(makeInstr(C_SW), C_SW, 2'd0, 1000);
    holdHalted(3);
    applyReset(1);

    // Unsupported opcode halts from DECODE.
    runInstr({6'h3f, 26'h1234567}, C_BAD, 2'd0, 0);
    holdHalted(2);
    applyReset(1);

    // Reset taken in the middle of an sw memory access.
    runInstr(makeInstr(C_ORI), C_ORI, 2'd0, 0);
    runInstr(makeInstr(C_J), C_J, 2'd0, 0);
    instr = makeInstr(C_SW);
    applyStimulus(1'b1, instr, 2'd0, 1'b0);
    checkCycle(0, C_SW, 2'd0, 1'b0);
    applyStimulus(1'b1, instr, 2'd0, 1'b0);
    checkCycle(1, C_SW, 2'd0, 1'b0);
    applyStimulus(1'b1, instr, 2'd0, 1'b0);
    checkCycle(2, C_SW, 2'd0, 1'b0);
    applyStimulus(1'b1, instr, 2'd0, 1'b0);
    checkCycle(3, C_SW, 2'd0, 1'b0);
    applyStimulus(1'b0, instr, 2'd0, 1'b0);
    checkOutput("reset_mid_mem_dm_we", 32'(cw_dm_write_enable), 32'd0);
    checkOutput("reset_mid_mem_strobes", 32'(strobes), 32'd0);
    model_count  = 32'd0;
    model_halted = 1'b0;
    runInstr(makeInstr(C_LUI), C_LUI, 2'd0, 0);
    runInstr(makeInstr(C_SUBU), C_SUBU, 2'd0, 0);

    // Random instruction stream with random waits and compare results.
    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(0, 8);
      r   = $urandom_range(0, 9);
      if (r < 8)       waits = r % 5;
      else if (r == 8) waits = TIMEOUT - 1;
      else             waits = TIMEOUT + 5;
      runInstr(makeInstr(cls), cls, 2'($urandom), waits);
      if (model_halted) begin
        holdHalted(2);
        applyReset($urandom_range(1, 2));
      end
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, the maximum number of MEM-state cycles to wait for mem_ready.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 curr_instr  in  32  instruction-register output, stable from DECODE onward.
REQ-005 alu_comp_result  in  2  ALU compare; CMP_EQ means num1==num2.
REQ-006 mem_ready  in  1  data-memory access completes this cycle.
REQ-007 cw_pc_enable, cw_im_enable, cw_ir_load, cw_rf_write_enable, cw_dm_write_enable, cw_dm_read_enable  out  1 each  datapath strobes.
REQ-008 cw_npc_jump_mode  out  2  NPC_SEQ / NPC_BRANCH / NPC_JUMP.
REQ-009 cw_alu_op  out  5; cw_ext_mode  out  3.
REQ-010 cm_rf_write_addr (0 rt, 1 rd), cm_rf_write_data (0 ALU, 1 DM), cm_alu_num2 (0 RF, 1 EXT)  out  1 each.
REQ-011 state  out  3  current FSM state; halted  out  1; instr_count  out  32  retired instructions.

Function
REQ-012 SHALL be a multi-cycle FSM: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. Encodings 5 and 6 are unused and SHALL go to HALT.
REQ-013 Outputs SHALL be combinational from the registered state and curr_instr. Any strobe not named for a state SHALL be 0 in that state.
REQ-014 FETCH SHALL assert cw_im_enable and cw_ir_load, then go to DECODE.
REQ-015 DECODE SHALL recognise addu (op 0, funct 0x21), subu (op 0, funct 0x23), ori 0x0d, lui 0x0f, lw 0x23, sw 0x2b, beq 0x04 and j 0x02. It SHALL go to EXEC for all of these. Any other encoding SHALL go to HALT.
REQ-016 EXEC SHALL drive the ALU controls as follows:
  - addu: ALU_ADD, num2=RF.
  - subu: ALU_SUB, num2=RF.
  - ori: ALU_OR, EXT_ZERO, num2=EXT.
  - lui: ALU_LUI, EXT_ZERO, num2=EXT.
  - lw/sw: ALU_ADD, EXT_SIGN, num2=EXT.
  - beq: ALU_SUB, num2=RF.
REQ-017 EXEC next state: addu/subu/ori/lui go to WB; lw/sw go to MEM.
REQ-018 beq SHALL assert cw_pc_enable in EXEC. jump_mode SHALL be NPC_BRANCH when alu_comp_result==CMP_EQ and NPC_SEQ otherwise. Next state SHALL be FETCH.
REQ-019 j SHALL assert cw_pc_enable with NPC_JUMP in EXEC, then go to FETCH.
REQ-020 In MEM, cw_dm_read_enable (lw) or cw_dm_write_enable (sw) SHALL stay high every cycle until mem_ready=1 is sampled.
REQ-021 On mem_ready=1: lw SHALL go to WB; sw SHALL assert cw_pc_enable (NPC_SEQ) in that same cycle and go to FETCH.
REQ-022 A wait counter SHALL count MEM cycles with mem_ready=0. At MEM_TIMEOUT consecutive waits the FSM SHALL go to HALT. mem_ready=1 in the timeout cycle SHALL win. The counter SHALL clear on MEM entry.
REQ-023 WB SHALL assert cw_rf_write_enable and cw_pc_enable (NPC_SEQ) for exactly one cycle.
  - cm_rf_write_addr: 1 for R-type, 0 otherwise.
  - cm_rf_write_data: 1 for lw only.
  - Next state: FETCH.
REQ-024 Instruction latency SHALL be:
  - beq/j: 3 cycles.
  - addu/subu/ori/lui: 4 cycles.
  - sw: 4+w cycles; lw: 5+w cycles, where w = MEM wait cycles.
REQ-025 instr_count SHALL increment by 1 on each cycle with cw_pc_enable=1, wrapping from 0xFFFFFFFF to 0.
REQ-026 HALT SHALL be absorbing with all strobes 0 and halted=1; only reset leaves it.

Reset
REQ-027 On rst_n=0 sampled at a rising edge, the block SHALL set state=FETCH, instr_count=0, wait counter=0 and halted=0.
REQ-028 During a reset cycle all strobes SHALL read 0, overriding state decode, including reset asserted in MEM or WB mid-instruction.
REQ-029 The first cycle after rst_n returns to 1 SHALL be FETCH with cw_im_enable=1.

Structure
REQ-030 Package mc_pkg SHALL hold:
  - State encodings.
  - ALU_ADD=5'd0, ALU_SUB=5'd1, ALU_OR=5'd2, ALU_LUI=5'd3.
  - EXT_ZERO=3'd0, EXT_SIGN=3'd1.
  - NPC_SEQ=2'd0, NPC_BRANCH=2'd1, NPC_JUMP=2'd2.
  - CMP_EQ=2'b00.
  - Opcode and funct constants.
REQ-031 One sub-module, mc_decode, SHALL map curr_instr to an instruction class plus a valid flag; the FSM and counters SHALL live in mc_control.

Verification
REQ-032 Reset, then addu (0x00851021): states 0,1,2,4,0; rd selected; rf_write one cycle; instr_count=1 after cycle 4.
REQ-033 lw with mem_ready low for 3 cycles: MEM held 4 cycles with read_enable high; WB data select=1; 8 cycles total.
REQ-034 beq with alu_comp_result=CMP_EQ, then beq with 2'b01: EXEC jump_mode 1 then 0; cw_pc_enable high in EXEC both times; 3 cycles each.
REQ-035 sw with mem_ready never asserted: 15 MEM cycles, then HALT with halted=1; no pc_enable; instr_count unchanged.
REQ-036 Opcode 0x3f: DECODE leads to HALT. Reset asserted while in MEM of an sw: dm_write_enable=0 in the reset cycle; state=0 and instr_count=0 next cycle.
